// File: rtl/b07_run_ctrl_if.sv
// b07_run_ctrl_if: request/result bundle between the system controller, the
// b07 run sequencer and the b07 instance. The master side is the environment
// (controller plus b07 punti_retta); the slave side is b07_run_ctrl.
interface b07_run_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             go;
    logic [7:0]       expected;
    logic             clear_err;
    logic [7:0]       punti_retta;
    logic             start;
    logic             busy;
    logic [7:0]       result;
    logic             result_valid;
    logic             mismatch;
    logic [CNT_W-1:0] run_count;
    logic [7:0]       max_result;

    modport master (
        output go, expected, clear_err, punti_retta,
        input  start, busy, result, result_valid, mismatch, run_count, max_result
    );

    modport slave (
        input  go, expected, clear_err, punti_retta,
        output start, busy, result, result_valid, mismatch, run_count, max_result
    );
endinterface

// File: rtl/b07_run_ctrl.sv
// b07_run_ctrl: run sequencer and result collector for the b07 point-line
// counter. Holds b07 start high for one full table scan, then samples the
// one-cycle punti_retta pulse during a start-low capture window, publishes the
// result with a strobe, checks it against an expected value and keeps stats.
// Optional feature macro: B07_RUN_AUTOREPEAT_EN (run trigger is the go level
// instead of the go rising edge, giving back-to-back runs while go is high).
module b07_run_ctrl #(
    parameter int unsigned START_HOLD  = 48,
    parameter int unsigned CAPTURE_WIN = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic          clock,
    input  logic          reset,
    b07_run_ctrl_if.slave bus
);
    localparam int unsigned HOLD_W = $clog2(START_HOLD) + 1;
    localparam int unsigned CAP_W  = $clog2(CAPTURE_WIN) + 1;

    typedef enum logic [1:0] {
        IDLE,
        START_HI,
        CAPTURE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              go_q;
    logic              trigger;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CAP_W-1:0]  cap_cnt;
    logic              hold_last;
    logic              cap_last;
    logic [7:0]        cap;
    logic [7:0]        cap_next;
    logic              capture_close;
    logic              start_next;

`ifdef B07_RUN_AUTOREPEAT_EN
    assign trigger = bus.go;
`else
    assign trigger = bus.go & ~go_q;
`endif

    assign hold_last     = (hold_cnt == HOLD_W'(START_HOLD - 1));
    assign cap_last      = (cap_cnt == CAP_W'(CAPTURE_WIN - 1));
    assign cap_next      = (bus.punti_retta > cap) ? bus.punti_retta : cap;
    assign capture_close = (state == CAPTURE) && cap_last;

    // go history for edge detection; tracks go every cycle, busy or not
    always_ff @(posedge clock) begin
        if (reset) begin
            go_q <= 1'b0;
        end else begin
            go_q <= bus.go;
        end
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state decode: fixed-length start-high and capture phases
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (trigger)   state_next = START_HI;
            START_HI: if (hold_last) state_next = CAPTURE;
            CAPTURE:  if (cap_last)  state_next = DONE;
            DONE:                    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // output decode: busy and result strobe from state, start from next state
    always_comb begin
        bus.busy         = (state != IDLE);
        bus.result_valid = (state == DONE);
        start_next       = (state_next == START_HI);
    end

    // start is registered so b07 sees a clean, glitch-free level
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.start <= 1'b0;
        end else begin
            bus.start <= start_next;
        end
    end

    // phase counters: each counts only inside its own phase and idles at 0
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt <= '0;
            cap_cnt  <= '0;
        end else begin
            if (state == START_HI) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end
            if (state == CAPTURE) begin
                cap_cnt <= cap_cnt + CAP_W'(1);
            end else begin
                cap_cnt <= '0;
            end
        end
    end

    // capture max of punti_retta over the window; b07 drives 0 outside its pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            cap <= '0;
        end else if ((state == IDLE) && trigger) begin
            cap <= '0;
        end else if (state == CAPTURE) begin
            cap <= cap_next;
        end
    end

    // Result and statistics load on the edge that closes the capture window,
    // using the window max including its last sample, so they are already
    // visible during the DONE cycle alongside result_valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.result     <= '0;
            bus.run_count  <= '0;
            bus.max_result <= '0;
        end else if (capture_close) begin
            bus.result    <= cap_next;
            bus.run_count <= bus.run_count + CNT_W'(1);
            if (cap_next > bus.max_result) begin
                bus.max_result <= cap_next;
            end
        end
    end

    // sticky mismatch; a new mismatch beats clear_err in the same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.mismatch <= 1'b0;
        end else if (capture_close && (cap_next != bus.expected)) begin
            bus.mismatch <= 1'b1;
        end else if (bus.clear_err) begin
            bus.mismatch <= 1'b0;
        end
    end
endmodule
